// File: rtl/pipeline_stage_register_if.sv
// Handshake bundle for one elastic pipeline stage: upstream side, downstream side
// and the hazard-unit controls. The slave modport is the stage's view.
interface pipeline_stage_register_if #(
    parameter int DATA_WIDTH = 96
);
    logic                  Stall_En;
    logic                  Flush;
    logic                  Valid_In;
    logic                  Ready_Out;
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Valid_Out;
    logic                  Ready_In;
    logic [DATA_WIDTH-1:0] Data_Out;
    logic [1:0]            Occupancy;

    modport slave (
        input  Stall_En, Flush, Valid_In, Data_In, Ready_In,
        output Ready_Out, Valid_Out, Data_Out, Occupancy
    );

    modport master (
        output Stall_En, Flush, Valid_In, Data_In, Ready_In,
        input  Ready_Out, Valid_Out, Data_Out, Occupancy
    );
endinterface

// File: rtl/pipeline_stage_register.sv
// Elastic pipeline stage register: valid/ready on both sides, optional skid entry,
// stall freezes everything, flush loads a bubble payload.
module pipeline_stage_register #(
    parameter int                    DATA_WIDTH   = 96,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = {32'h0000_0013, 32'h2A2A_2A2A, 32'h2A2A_2A2A},
    parameter bit                    BUBBLE_VALID = 1'b1,
    parameter bit                    SKID_EN      = 1'b1
) (
    input  logic                            CLK,
    input  logic                            RST,
    pipeline_stage_register_if.slave        bus
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] w_main_nxt;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [DATA_WIDTH-1:0] w_skid_nxt;

    logic w_valid;
    logic w_ready;
    logic w_hold_off;
    logic w_accept;
    logic w_drain;

    assign w_valid    = (r_state != EMPTY);
    assign w_hold_off = bus.Stall_En | bus.Flush;

    // Without the skid entry, ready looks through to the downstream ready.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign w_ready = (r_state != FULL) & ~w_hold_off;
        end else begin : g_pass_ready
            assign w_ready = (~w_valid | bus.Ready_In) & ~w_hold_off;
        end
    endgenerate

    assign w_accept = bus.Valid_In & w_ready;
    assign w_drain  = w_valid & bus.Ready_In & ~w_hold_off;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (!bus.Stall_En) begin
            if (bus.Flush) begin
                w_main_nxt  = BUBBLE_VALUE;
                w_state_nxt = BUBBLE_VALID ? ONE : EMPTY;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_accept) begin
                            w_main_nxt  = bus.Data_In;
                            w_state_nxt = ONE;
                        end
                    end
                    ONE: begin
                        if (w_accept && w_drain) begin
                            w_main_nxt = bus.Data_In;
                        end else if (w_accept && SKID_EN) begin
                            w_skid_nxt  = bus.Data_In;
                            w_state_nxt = FULL;
                        end else if (w_drain) begin
                            w_state_nxt = EMPTY;
                        end
                    end
                    FULL: begin
                        if (w_drain) begin
                            w_main_nxt  = r_skid;
                            w_state_nxt = ONE;
                        end
                    end
                    default: w_state_nxt = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    assign bus.Ready_Out = w_ready;
    assign bus.Valid_Out = w_valid;
    assign bus.Data_Out  = r_main;
    assign bus.Occupancy = r_state;

`ifndef SYNTHESIS
    a_state_legal: assert property (@(posedge CLK) disable iff (RST)
        (r_state != FULL) || SKID_EN)
        else $error("pipeline_stage_register: FULL reached without skid entry");
`endif

endmodule
